// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// FSM state encoding and the register-match helper used by forwarding.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int WAIT_W = 8;

    // A later stage supplies the operand when it writes a non-x0 register matching the source.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand in Execute; Memory-stage result
// takes priority over Writeback.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd
);

    // Operand source priority: Memory, then Writeback, else register file.
    always_comb begin
        fwd = FWD_RF;
        if (reg_hit(reg_write_m, rd_m, rs)) begin
            fwd = FWD_M;
        end else if (reg_hit(reg_write_w, rd_w, rs)) begin
            fwd = FWD_W;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding
// and data-memory wait FSM with timeout. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 mem_req_M,
    input  logic                 mem_ready_M,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 mem_wait,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_r;
    hz_state_t         state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              mem_err_r;
    logic              mem_err_nxt_s;
    logic              mem_wait_r;
    logic              timeout_hit_s;
    logic              mem_stall_s;
    logic              lw_stall_s;
    fwd_sel_t          fwd_a_s;
    fwd_sel_t          fwd_b_s;

    assign timeout_hit_s = (state_r == MEM_WAIT) && (wait_cnt_r == TIMEOUT_C);
    assign mem_stall_s   = mem_req_M && !mem_ready_M && !timeout_hit_s;
    assign lw_stall_s    = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a_s)
    );

    fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b_s)
    );

    // Memory-wait FSM next state, wait counter and sticky timeout flag.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        mem_err_nxt_s  = mem_err_r;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = 8'd1;
                end else begin
                    state_nxt_s    = RUN;
                    wait_cnt_nxt_s = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_M) begin
                    state_nxt_s    = RUN;
                    wait_cnt_nxt_s = 8'd0;
                end else if (timeout_hit_s) begin
                    state_nxt_s    = RUN;
                    wait_cnt_nxt_s = 8'd0;
                    mem_err_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // FSM state, counter, error flag and registered wait indication.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
            mem_err_r  <= 1'b0;
            mem_wait_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            mem_err_r  <= mem_err_nxt_s;
            mem_wait_r <= (state_nxt_s == MEM_WAIT);
        end
    end

    assign mem_wait = mem_wait_r;
    assign mem_err  = mem_err_r;

    // Stall/flush decode; a memory stall freezes everything and defers any branch flush.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            StallF = 1'b0;
        end else if (mem_stall_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall_s;
            StallD = lw_stall_s;
            FlushE = lw_stall_s | PCSrcE;
            FlushD = PCSrcE;
        end
    end

    // Forwarding selects, forced to the register file while in reset.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cycles_r;
    logic [CNT_WIDTH-1:0] flush_events_r;
    logic                 any_stall_s;
    logic                 any_flush_s;

    assign any_stall_s = StallF | StallD | StallE | StallM;
    assign any_flush_s = FlushD | FlushE;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_r <= {CNT_WIDTH{1'b0}};
            flush_events_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (any_stall_s && (stall_cycles_r != CNT_MAX_C)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE_C;
            end
            if (any_flush_s && (flush_events_r != CNT_MAX_C)) begin
                flush_events_r <= flush_events_r + CNT_ONE_C;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;
`else
    assign stall_cycles = {CNT_WIDTH{1'b0}};
    assign flush_events = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4): each cycle's expected
// outputs are queued at drive time and compared at the following negedge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       lw, pcsrc;
        logic [4:0] rdm, rdw;
        logic       wem, wew, req, rdy;
    } vin_t;

    // sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    typedef struct packed {
        logic [6:0]  sf;
        logic [1:0]  fa, fb;
        logic        mw, me;
        logic [31:0] sc, fe;
    } obs_t;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_MEM  = 7'b1111001;
    localparam logic [6:0] S_LW   = 7'b1100010;
    localparam logic [6:0] S_BR   = 7'b0000110;
    localparam logic [6:0] S_LWBR = 7'b1100110;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] Rs1D = 5'd0, Rs2D = 5'd0, Rs1E = 5'd0, Rs2E = 5'd0, RdE = 5'd0;
    logic ResultSrcE0 = 1'b0, PCSrcE = 1'b0;
    logic [4:0] RdM = 5'd0, RdW = 5'd0;
    logic RegWriteM = 1'b0, RegWriteW = 1'b0, mem_req_M = 1'b0, mem_ready_M = 1'b0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic mem_wait, mem_err;
    logic [31:0] stall_cycles, flush_events;

    obs_t sb[$];
    obs_t got, exp_o;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_sc = 32'd0;
    logic [31:0] m_fe = 32'd0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_wait(mem_wait), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    function automatic vin_t vi();
        vin_t v;
        v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic obs_t mk(input logic [6:0] sf, input logic [1:0] fa, input logic [1:0] fb,
                                input logic mw, input logic me);
        obs_t o;
        o = '0;
        o.sf = sf; o.fa = fa; o.fb = fb; o.mw = mw; o.me = me;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        o.fa = ForwardAE; o.fb = ForwardBE;
        o.mw = mem_wait;  o.me = mem_err;
        o.sc = stall_cycles; o.fe = flush_events;
        return o;
    endfunction

    // Apply one cycle of stimulus and queue its expected outputs, counters included.
    task automatic drive(input vin_t v, input obs_t e);
        @(posedge clk);
        #1;
        reset = v.rst; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; ResultSrcE0 = v.lw; PCSrcE = v.pcsrc; RdM = v.rdm; RdW = v.rdw;
        RegWriteM = v.wem; RegWriteW = v.wew; mem_req_M = v.req; mem_ready_M = v.rdy;
        e.sc = m_sc;
        e.fe = m_fe;
        sb.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
        if (!v.rst) begin
            m_sc = 32'd0;
            m_fe = 32'd0;
        end else begin
            if (e.sf[6:3] != 4'b0000 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (e.sf[2:1] != 2'b00 && m_fe != 32'hFFFF_FFFF) m_fe = m_fe + 32'd1;
        end
`endif
    endtask

    task automatic test_reset();
        vin_t v[3]; obs_t e[3];
        v[0] = vi(); v[0].rst = 1'b0; v[0].lw = 1'b1; v[0].rde = 5'd5; v[0].rs1d = 5'd5;
        v[0].pcsrc = 1'b1; v[0].req = 1'b1; v[0].wem = 1'b1; v[0].rdm = 5'd3; v[0].rs1e = 5'd3;
        e[0] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[1] = vi(); v[1].rst = 1'b0; v[1].wew = 1'b1; v[1].rdw = 5'd7; v[1].rs2e = 5'd7;
        e[1] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[2] = vi();
        e[2] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_load_use();
        vin_t v[4]; obs_t e[4];
        v[0] = vi(); v[0].lw = 1'b1; v[0].rde = 5'd5; v[0].rs1d = 5'd5;
        e[0] = mk(S_LW, 2'b00, 2'b00, 1'b0, 1'b0);
        v[1] = vi(); v[1].lw = 1'b1; v[1].rde = 5'd0; v[1].rs1d = 5'd0;
        e[1] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[2] = vi(); v[2].lw = 1'b1; v[2].rde = 5'd12; v[2].rs1d = 5'd4; v[2].rs2d = 5'd12;
        e[2] = mk(S_LW, 2'b00, 2'b00, 1'b0, 1'b0);
        v[3] = vi(); v[3].rde = 5'd12; v[3].rs2d = 5'd12;
        e[3] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL load_use[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_branch();
        vin_t v[3]; obs_t e[3];
        v[0] = vi(); v[0].pcsrc = 1'b1;
        e[0] = mk(S_BR, 2'b00, 2'b00, 1'b0, 1'b0);
        v[1] = vi(); v[1].pcsrc = 1'b1; v[1].lw = 1'b1; v[1].rde = 5'd9; v[1].rs2d = 5'd9;
        e[1] = mk(S_LWBR, 2'b00, 2'b00, 1'b0, 1'b0);
        v[2] = vi();
        e[2] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL branch[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_forward();
        vin_t v[5]; obs_t e[5];
        v[0] = vi(); v[0].wem = 1'b1; v[0].rdm = 5'd3; v[0].wew = 1'b1; v[0].rdw = 5'd3; v[0].rs1e = 5'd3;
        e[0] = mk(S_NONE, 2'b10, 2'b00, 1'b0, 1'b0);
        v[1] = v[0]; v[1].wem = 1'b0;
        e[1] = mk(S_NONE, 2'b01, 2'b00, 1'b0, 1'b0);
        v[2] = v[0]; v[2].rdm = 5'd0; v[2].rdw = 5'd0; v[2].rs1e = 5'd0;
        e[2] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[3] = vi(); v[3].wew = 1'b1; v[3].rdw = 5'd7; v[3].rs2e = 5'd7; v[3].rs1e = 5'd6;
        e[3] = mk(S_NONE, 2'b00, 2'b01, 1'b0, 1'b0);
        v[4] = vi(); v[4].wem = 1'b1; v[4].rdm = 5'd31; v[4].wew = 1'b1; v[4].rdw = 5'd8;
        v[4].rs1e = 5'd8; v[4].rs2e = 5'd31;
        e[4] = mk(S_NONE, 2'b01, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL forward[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_mem_stall();
        vin_t v[7]; obs_t e[7];
        vin_t b;
        b = vi(); b.req = 1'b1; b.lw = 1'b1; b.rde = 5'd5; b.rs1d = 5'd5;
        b.wem = 1'b1; b.rdm = 5'd3; b.rs1e = 5'd3; b.wew = 1'b1; b.rdw = 5'd4; b.rs2e = 5'd4;
        for (int i = 0; i < 3; i++) begin
            v[i] = b;
            e[i] = mk(S_MEM, 2'b10, 2'b01, (i != 0), 1'b0);
        end
        v[3] = b; v[3].rdy = 1'b1;
        e[3] = mk(S_LW, 2'b10, 2'b01, 1'b1, 1'b0);
        v[4] = vi();
        e[4] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[5] = vi(); v[5].req = 1'b1; v[5].rdy = 1'b1;
        e[5] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[6] = vi();
        e[6] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL mem_stall[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_branch_during_stall();
        vin_t v[4]; obs_t e[4];
        v[0] = vi(); v[0].req = 1'b1; v[0].pcsrc = 1'b1;
        e[0] = mk(S_MEM, 2'b00, 2'b00, 1'b0, 1'b0);
        v[1] = v[0];
        e[1] = mk(S_MEM, 2'b00, 2'b00, 1'b1, 1'b0);
        v[2] = v[0]; v[2].rdy = 1'b1;
        e[2] = mk(S_BR, 2'b00, 2'b00, 1'b1, 1'b0);
        v[3] = vi();
        e[3] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL branch_in_stall[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        vin_t v[5]; obs_t e[5];
        v[0] = vi(); v[0].req = 1'b1;
        e[0] = mk(S_MEM, 2'b00, 2'b00, 1'b0, 1'b0);
        v[1] = v[0];
        e[1] = mk(S_MEM, 2'b00, 2'b00, 1'b1, 1'b0);
        v[2] = v[0]; v[2].rst = 1'b0;
        e[2] = mk(S_NONE, 2'b00, 2'b00, 1'b1, 1'b0);
        v[3] = vi();
        e[3] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        v[4] = vi();
        e[4] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL reset_mid_wait[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    // With MEM_TIMEOUT=4 the fifth waiting cycle hits the timeout and releases the stall.
    task automatic test_timeout();
        vin_t v[7]; obs_t e[7];
        for (int i = 0; i < 5; i++) begin
            v[i] = vi(); v[i].req = 1'b1;
            e[i] = mk((i < 4) ? S_MEM : S_NONE, 2'b00, 2'b00, (i != 0), 1'b0);
        end
        v[5] = vi();
        e[5] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b1);
        v[6] = vi(); v[6].pcsrc = 1'b1;
        e[6] = mk(S_BR, 2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL timeout[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_err_clear();
        vin_t v[3]; obs_t e[3];
        v[0] = vi();
        e[0] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b1);
        v[1] = vi(); v[1].rst = 1'b0;
        e[1] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b1);
        v[2] = vi();
        e[2] = mk(S_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(v[i], e[i]);
            @(negedge clk);
            got = sample(); exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL err_clear[%0d] got=%h expected=%h", i, got, exp_o);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_forward();
        test_mem_stall();
        test_branch_during_stall();
        test_reset_mid_wait();
        test_timeout();
        test_err_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
